// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FSM type, bit-reverse and complex fixed-point butterfly helpers
package fft_pkg;

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

   // Arithmetic is done in a wide container and truncated by the caller; wrap
   // behaviour is unchanged because only the low BIT_WIDTH bits are kept.
   localparam int CW = 64;

   typedef struct packed {
      logic signed [CW-1:0] re;
      logic signed [CW-1:0] im;
   } cplx_t;

   typedef struct packed {
      cplx_t top;
      cplx_t bot;
   } bfly_t;

   function automatic int bit_reverse(input int idx, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) r = (r << 1) | ((idx >> i) & 1);
      return r;
   endfunction

   function automatic logic signed [CW-1:0] fx_mul(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input int dp);
      logic signed [2*CW-1:0] p;
      p = (2*CW)'(a) * (2*CW)'(b);
      return CW'(p >>> dp);
   endfunction

   function automatic cplx_t cmul(input cplx_t a, input cplx_t b, input int dp);
      cplx_t r;
      r.re = fx_mul(a.re, b.re, dp) - fx_mul(a.im, b.im, dp);
      r.im = fx_mul(a.re, b.im, dp) + fx_mul(a.im, b.re, dp);
      return r;
   endfunction

   function automatic bfly_t butterfly(input cplx_t a, input cplx_t b, input cplx_t w, input int dp);
      bfly_t r;
      cplx_t wb;
      wb = cmul(w, b, dp);
      r.top.re = a.re + wb.re;
      r.top.im = a.im + wb.im;
      r.bot.re = a.re - wb.re;
      r.bot.im = a.im - wb.im;
      return r;
   endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// rtl/fft_twiddle_rom.sv - constant cos/sin twiddle words for one N-point FFT
module fft_twiddle_rom #(
   parameter int BIT_WIDTH  = 32,
   parameter int DECIMAL_PT = 16,
   parameter int N_SAMPLES  = 8
) (
   output logic [N_SAMPLES/2-1:0][BIT_WIDTH-1:0] cos_w,
   output logic [N_SAMPLES/2-1:0][BIT_WIDTH-1:0] sin_w
);

   // Quarter-wave cos(2*pi*i/64) in Q2.30; every supported N indexes a subset.
   function automatic logic signed [32:0] quarter_q30(input int i);
      case (i)
         0:       return 33'sd1073741824;
         1:       return 33'sd1068571464;
         2:       return 33'sd1053110176;
         3:       return 33'sd1027506861;
         4:       return 33'sd992008094;
         5:       return 33'sd946955747;
         6:       return 33'sd892783698;
         7:       return 33'sd830013650;
         8:       return 33'sd759250125;
         9:       return 33'sd681174598;
         10:      return 33'sd596538995;
         11:      return 33'sd506158395;
         12:      return 33'sd410903207;
         13:      return 33'sd311690802;
         14:      return 33'sd209476638;
         15:      return 33'sd105245103;
         default: return 33'sd0;
      endcase
   endfunction

   function automatic logic signed [32:0] cos64(input int i);
      return (i <= 16) ? quarter_q30(i) : -quarter_q30(32 - i);
   endfunction

   function automatic logic signed [32:0] sin64(input int i);
      return (i <= 16) ? quarter_q30(16 - i) : quarter_q30(i - 16);
   endfunction

   function automatic logic [BIT_WIDTH-1:0] to_fix(input logic signed [32:0] v);
      logic signed [32:0] r;
      r = (v + (33'sd1 <<< (29 - DECIMAL_PT))) >>> (30 - DECIMAL_PT);
      return BIT_WIDTH'(r);
   endfunction

   for (genvar t = 0; t < N_SAMPLES / 2; t++) begin : g_word
      assign cos_w[t] = to_fix(cos64(t * (64 / N_SAMPLES)));
      assign sin_w[t] = to_fix(sin64(t * (64 / N_SAMPLES)));
   end

endmodule

// File: rtl/fft_iterative_complex.sv
// rtl/fft_iterative_complex.sv - radix-2 DIT FFT/IFFT, one butterfly stage per cycle
module fft_iterative_complex
   import fft_pkg::*;
#(
   parameter int BIT_WIDTH  = 32,
   parameter int DECIMAL_PT = 16,
   parameter int N_SAMPLES  = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_real,
   input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_imag,
   input  logic                                recv_inverse,
   input  logic                                recv_val,
   output logic                                recv_rdy,
   output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_real,
   output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_imag,
   output logic                                send_val,
   input  logic                                send_rdy
);

   localparam int LOG2N = $clog2(N_SAMPLES);
   localparam int HALF  = N_SAMPLES / 2;
   localparam int SW    = $clog2(LOG2N + 1);
   localparam int TW    = (LOG2N > 1) ? LOG2N - 1 : 1;

   typedef logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] bank_t;

   state_e        state_q, state_d;
   logic [SW-1:0] stage_q, stage_d;
   bank_t         re_q, re_d, im_q, im_d;
   logic          inv_q, inv_d;

   logic [HALF-1:0][BIT_WIDTH-1:0] cos_w, sin_w;
   logic [HALF-1:0][BIT_WIDTH-1:0] top_re, top_im, bot_re, bot_im;
   logic [HALF-1:0][LOG2N-1:0]     top_idx, bot_idx;

   fft_twiddle_rom #(
      .BIT_WIDTH (BIT_WIDTH),
      .DECIMAL_PT(DECIMAL_PT),
      .N_SAMPLES (N_SAMPLES)
   ) u_rom (
      .cos_w(cos_w),
      .sin_w(sin_w)
   );

   for (genvar k = 0; k < HALF; k++) begin : g_bfly
      int               s, span, pos, top, t;
      logic [LOG2N-1:0] top_i, bot_i;
      logic [TW-1:0]    t_i;
      cplx_t            a, b, w;
      bfly_t            r;

      always_comb begin
         s     = int'(stage_q);
         span  = 1 << s;
         pos   = k & (span - 1);
         top   = ((k >> s) << (s + 1)) + pos;
         t     = pos * (N_SAMPLES >> (s + 1));
         top_i = LOG2N'(top);
         bot_i = LOG2N'(top + span);
         t_i   = TW'(t);
         a.re  = CW'(signed'(re_q[top_i]));
         a.im  = CW'(signed'(im_q[top_i]));
         b.re  = CW'(signed'(re_q[bot_i]));
         b.im  = CW'(signed'(im_q[bot_i]));
         w.re  = CW'(signed'(cos_w[t_i]));
         // Inverse transform conjugates the twiddle.
         w.im  = inv_q ? CW'(signed'(sin_w[t_i])) : -CW'(signed'(sin_w[t_i]));
         r     = butterfly(a, b, w, DECIMAL_PT);
      end

      assign top_idx[k] = top_i;
      assign bot_idx[k] = bot_i;
      assign top_re[k]  = BIT_WIDTH'(r.top.re);
      assign top_im[k]  = BIT_WIDTH'(r.top.im);
      assign bot_re[k]  = BIT_WIDTH'(r.bot.re);
      assign bot_im[k]  = BIT_WIDTH'(r.bot.im);
   end

   assign recv_rdy = !reset && (state_q == IDLE || (state_q == DONE && send_rdy));
   assign send_val = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      re_d    = re_q;
      im_d    = im_q;
      inv_d   = inv_q;
      case (state_q)
         COMPUTE: begin
            for (int k = 0; k < HALF; k++) begin
               re_d[top_idx[k]] = top_re[k];
               im_d[top_idx[k]] = top_im[k];
               re_d[bot_idx[k]] = bot_re[k];
               im_d[bot_idx[k]] = bot_im[k];
            end
            if (stage_q == SW'(LOG2N - 1)) begin
               state_d = DONE;
               stage_d = '0;
            end else begin
               stage_d = stage_q + SW'(1);
            end
         end
         DONE:    if (send_rdy) state_d = IDLE;
         default: ;
      endcase
      // A frame accepted in DONE overrides the drain-to-IDLE transition.
      if (recv_val && recv_rdy) begin
         for (int k = 0; k < N_SAMPLES; k++) begin
            re_d[LOG2N'(bit_reverse(k, LOG2N))] = recv_real[k];
            im_d[LOG2N'(bit_reverse(k, LOG2N))] = recv_imag[k];
         end
         inv_d   = recv_inverse;
         stage_d = '0;
         state_d = COMPUTE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         stage_q <= '0;
         re_q    <= '0;
         im_q    <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         re_q    <= re_d;
         im_q    <= im_d;
         inv_q   <= inv_d;
      end
   end

   always_comb begin
      send_real = re_q;
      send_imag = im_q;
      if (inv_q) begin
         for (int k = 0; k < N_SAMPLES; k++) begin
            send_real[k] = $signed(re_q[k]) >>> LOG2N;
            send_imag[k] = $signed(im_q[k]) >>> LOG2N;
         end
      end
   end

endmodule
